// File: rtl/mult32x32_pkg.sv
// Shared widths and shift_sel encodings for the fast 32x32 multiplier.
package mult32x32_pkg;

  localparam int unsigned OPW        = 32;
  localparam int unsigned PRODW      = 64;
  localparam int unsigned A_BYTEW    = 8;
  localparam int unsigned B_WORDW    = 16;
  localparam int unsigned PPW        = 24;
  localparam int unsigned SHIFT_STEP = 8;
  localparam int unsigned SHSELW     = 3;

  // shift_sel codes: partial product shifted left by the named bit count
  localparam logic [SHSELW-1:0] SH_0  = 3'd0;
  localparam logic [SHSELW-1:0] SH_8  = 3'd1;
  localparam logic [SHSELW-1:0] SH_16 = 3'd2;
  localparam logic [SHSELW-1:0] SH_24 = 3'd3;
  localparam logic [SHSELW-1:0] SH_32 = 3'd4;
  localparam logic [SHSELW-1:0] SH_40 = 3'd5;

endpackage

// File: rtl/mult8x16.sv
// Purely combinational 8x16 unsigned multiplier with a 24-bit result.
module mult8x16
  import mult32x32_pkg::*;
(
  input  logic [A_BYTEW-1:0] a,
  input  logic [B_WORDW-1:0] b,
  output logic [PPW-1:0]     p
);

  // Both operands widened to the full result width so nothing is truncated
  assign p = PPW'(a) * PPW'(b);

endmodule

// File: rtl/mult32x32_fast_arith.sv
// Datapath of the fast 32x32 multiplier: operand latches, 8x16 partial
// product, alignment, 64-bit accumulation and the operand status flags.
module mult32x32_fast_arith
  import mult32x32_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    a,
  input  logic [OPW-1:0]    b,
  input  logic [1:0]        a_sel,
  input  logic              b_sel,
  input  logic [SHSELW-1:0] shift_sel,
  input  logic              upd_prod,
  input  logic              clr_prod,
  output logic              a_msb_is_0,
  output logic              b_msw_is_0,
  output logic [PRODW-1:0]  product
);

  logic [OPW-1:0]     a_q;
  logic [OPW-1:0]     b_q;
  logic [A_BYTEW-1:0] a_byte;
  logic [B_WORDW-1:0] b_word;
  logic [PPW-1:0]     pp;
  logic [PRODW-1:0]   aligned;

  // Operands are captured only on the start cycle; a/b are free afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (clr_prod) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Byte select of latched A; every a_sel code is decoded
  always_comb begin
    a_byte = '0;
    case (a_sel)
      2'd0:    a_byte = a_q[7:0];
      2'd1:    a_byte = a_q[15:8];
      2'd2:    a_byte = a_q[23:16];
      default: a_byte = a_q[31:24];
    endcase
  end

  // Word select of latched B
  always_comb begin
    b_word = b_sel ? b_q[31:16] : b_q[15:0];
  end

  mult8x16 u_mult8x16 (
    .a (a_byte),
    .b (b_word),
    .p (pp)
  );

  // Align partial product by whole bytes; codes 6 and 7 contribute nothing
  always_comb begin
    aligned = '0;
    case (shift_sel)
      SH_0:    aligned = PRODW'(pp);
      SH_8:    aligned = PRODW'(pp) << (1 * SHIFT_STEP);
      SH_16:   aligned = PRODW'(pp) << (2 * SHIFT_STEP);
      SH_24:   aligned = PRODW'(pp) << (3 * SHIFT_STEP);
      SH_32:   aligned = PRODW'(pp) << (4 * SHIFT_STEP);
      SH_40:   aligned = PRODW'(pp) << (5 * SHIFT_STEP);
      default: aligned = '0;
    endcase
  end

  // Product accumulator: clear has priority over accumulate, sum wraps mod 2^64
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= '0;
    end else if (clr_prod) begin
      product <= '0;
    end else if (upd_prod) begin
      product <= product + aligned;
    end
  end

  // Status flags the FSM branches on, from latched operands only
  assign a_msb_is_0 = (a_q[31:24] == '0);
  assign b_msw_is_0 = (b_q[31:16] == '0);

endmodule
